// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: sideband message codes and the step FSM state encoding.
// Imported by both the TX-side initiator and the RX-side responder.
package mbtrain_pkg;

    localparam logic [3:0] SB_NONE       = 4'b0000;
    localparam logic [3:0] SB_START_REQ  = 4'b0001;
    localparam logic [3:0] SB_START_RESP = 4'b0010;
    localparam logic [3:0] SB_END_REQ    = 4'b0011;
    localparam logic [3:0] SB_END_RESP   = 4'b0100;

    localparam logic [2:0] ST_IDLE            = 3'd0;
    localparam logic [2:0] ST_SEND_START_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT_START_RESP = 3'd2;
    localparam logic [2:0] ST_CAL_ALGO        = 3'd3;
    localparam logic [2:0] ST_SEND_END_REQ    = 3'd4;
    localparam logic [2:0] ST_WAIT_END_RESP   = 3'd5;
    localparam logic [2:0] ST_TEST_FINISHED   = 3'd6;

    localparam int LANES = 16;

    // States in which a sideband response is pending and the timeout runs.
    function automatic logic is_wait_state(input logic [2:0] st);
        return (st == ST_WAIT_START_RESP) || (st == ST_WAIT_END_RESP);
    endfunction

endpackage

// File: rtl/train_center_cal_tx_if.sv
// Sideband and point-test signal bundle for the center-calibration TX step.
// master = the TX step block, slave = its environment (controller, sideband, point test).
interface train_center_cal_tx_if;
    logic        i_en;
    logic [3:0]  i_decoded_sideband_message;
    logic        i_busy_negedge_detected;
    logic        i_valid_rx;
    logic        i_mainband_or_valtrain_test;
    logic        i_lfsr_or_perlane;
    logic        i_test_ack;
    logic [15:0] i_tx_lanes_result;
    logic [3:0]  o_sideband_message;
    logic        o_valid_tx;
    logic        o_pt_en;
    logic        o_eye_width_sweep_en;
    logic        o_test_ack;
    logic [15:0] o_lanes_result;
    logic        o_timeout;

    modport master (
        input  i_en, i_decoded_sideband_message, i_busy_negedge_detected, i_valid_rx,
               i_mainband_or_valtrain_test, i_lfsr_or_perlane, i_test_ack, i_tx_lanes_result,
        output o_sideband_message, o_valid_tx, o_pt_en, o_eye_width_sweep_en,
               o_test_ack, o_lanes_result, o_timeout
    );

    modport slave (
        output i_en, i_decoded_sideband_message, i_busy_negedge_detected, i_valid_rx,
               i_mainband_or_valtrain_test, i_lfsr_or_perlane, i_test_ack, i_tx_lanes_result,
        input  o_sideband_message, o_valid_tx, o_pt_en, o_eye_width_sweep_en,
               o_test_ack, o_lanes_result, o_timeout
    );
endinterface

// File: rtl/train_center_cal_tx_sb_valid_ctrl.sv
// Sideband request register: latches a message with valid, drops valid when the
// serializer reports completion, and flags the valid falling edge. Reusable by MBTRAIN TX steps.
module sb_valid_ctrl #(
    parameter int MSG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  logic [MSG_W-1:0] i_set_msg,
    input  logic             i_clr,
    input  logic             i_flush,
    output logic [MSG_W-1:0] o_msg,
    output logic             o_valid,
    output logic             o_valid_fall
);
    logic [MSG_W-1:0] r_msg;
    logic             r_valid;
    logic             r_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg     <= '0;
            r_valid   <= 1'b0;
            r_valid_d <= 1'b0;
        end else if (i_flush) begin
            r_msg     <= '0;
            r_valid   <= 1'b0;
            r_valid_d <= 1'b0;
        end else begin
            r_valid_d <= r_valid;
            // A completion pulse on the set edge belongs to an earlier message: set wins.
            if (i_set) begin
                r_msg   <= i_set_msg;
                r_valid <= 1'b1;
            end else if (i_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_msg        = r_msg;
    assign o_valid      = r_valid;
    assign o_valid_fall = r_valid_d & ~r_valid;
endmodule

// File: rtl/train_center_cal_tx.sv
// MBTRAIN center-calibration initiator: start req/resp handshake, point test,
// end req/resp handshake, with a per-response timeout.
module train_center_cal_tx
    import mbtrain_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    train_center_cal_tx_if.master   io_if
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       r_cs;
    logic [2:0]       w_ns;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pt_en;
    logic             r_sweep_en;
    logic             r_test_ack;
    logic             r_timeout;
    logic [LANES-1:0] r_lanes;

    logic             w_expire;
    logic             w_start_resp;
    logic             w_end_resp;
    logic             w_set;
    logic [3:0]       w_set_msg;
    logic             w_flush;
    logic             w_valid_fall;

    // TX owns the sideband unconditionally; the RX valid is only observed by the environment.
    logic w_unused_valid_rx;
    assign w_unused_valid_rx = io_if.i_valid_rx ^ io_if.i_lfsr_or_perlane;

    assign w_expire     = (r_cnt == TO_LAST);
    assign w_start_resp = (io_if.i_decoded_sideband_message == SB_START_RESP);
    assign w_end_resp   = (io_if.i_decoded_sideband_message == SB_END_RESP);

    always_comb begin
        w_ns = r_cs;
        if (r_cs != ST_IDLE && !io_if.i_en) begin
            w_ns = ST_IDLE;
        end else begin
            case (r_cs)
                ST_IDLE:            if (io_if.i_en)    w_ns = ST_SEND_START_REQ;
                ST_SEND_START_REQ:  if (w_valid_fall)  w_ns = ST_WAIT_START_RESP;
                ST_WAIT_START_RESP: begin
                    if (w_start_resp)  w_ns = ST_CAL_ALGO;
                    else if (w_expire) w_ns = ST_TEST_FINISHED;
                end
                ST_CAL_ALGO:        if (io_if.i_test_ack) w_ns = ST_SEND_END_REQ;
                ST_SEND_END_REQ:    if (w_valid_fall)  w_ns = ST_WAIT_END_RESP;
                ST_WAIT_END_RESP: begin
                    if (w_end_resp)    w_ns = ST_TEST_FINISHED;
                    else if (w_expire) w_ns = ST_TEST_FINISHED;
                end
                ST_TEST_FINISHED:   w_ns = ST_TEST_FINISHED;
                default:            w_ns = ST_IDLE;
            endcase
        end
    end

    assign w_set     = ((r_cs == ST_IDLE)     && (w_ns == ST_SEND_START_REQ)) ||
                       ((r_cs == ST_CAL_ALGO) && (w_ns == ST_SEND_END_REQ));
    assign w_set_msg = (r_cs == ST_IDLE) ? SB_START_REQ : SB_END_REQ;
    assign w_flush   = (w_ns == ST_IDLE);

    sb_valid_ctrl #(.MSG_W(4)) u_sb_valid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set        (w_set),
        .i_set_msg    (w_set_msg),
        .i_clr        (io_if.i_busy_negedge_detected),
        .i_flush      (w_flush),
        .o_msg        (io_if.o_sideband_message),
        .o_valid      (io_if.o_valid_tx),
        .o_valid_fall (w_valid_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs       <= ST_IDLE;
            r_cnt      <= '0;
            r_pt_en    <= 1'b0;
            r_sweep_en <= 1'b0;
            r_test_ack <= 1'b0;
            r_timeout  <= 1'b0;
            r_lanes    <= '0;
        end else begin
            r_cs  <= w_ns;
            // Cleared outside WAIT_*, so every WAIT_* entry starts counting from zero.
            r_cnt <= is_wait_state(r_cs) ? r_cnt + 1'b1 : '0;
            if (w_ns == ST_IDLE) begin
                r_pt_en    <= 1'b0;
                r_sweep_en <= 1'b0;
                r_test_ack <= 1'b0;
                r_timeout  <= 1'b0;
                r_lanes    <= '0;
            end else begin
                if (r_cs == ST_WAIT_START_RESP && w_ns == ST_CAL_ALGO) begin
                    r_pt_en    <= 1'b1;
                    r_sweep_en <= ~io_if.i_mainband_or_valtrain_test;
                end
                if (r_cs == ST_CAL_ALGO && w_ns == ST_SEND_END_REQ) begin
                    r_pt_en    <= 1'b0;
                    r_sweep_en <= 1'b0;
                    r_lanes    <= io_if.i_tx_lanes_result;
                end
                // A matching response on the expiry cycle completes normally.
                if (r_cs != ST_TEST_FINISHED && w_ns == ST_TEST_FINISHED) begin
                    if (r_cs == ST_WAIT_END_RESP && w_end_resp) r_test_ack <= 1'b1;
                    else                                        r_timeout  <= 1'b1;
                end
            end
        end
    end

    assign io_if.o_pt_en              = r_pt_en;
    assign io_if.o_eye_width_sweep_en = r_sweep_en;
    assign io_if.o_test_ack           = r_test_ack;
    assign io_if.o_lanes_result       = r_lanes;
    assign io_if.o_timeout            = r_timeout;
endmodule

// File: tb/tb_train_center_cal_tx.sv
// Directed bench for train_center_cal_tx with a short timeout (16 cycles).
module tb_train_center_cal_tx;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    train_center_cal_tx_if bus();

    train_center_cal_tx #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_if (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, bus.o_sideband_message, bus.o_valid_tx, bus.o_pt_en,
                bus.o_eye_width_sweep_en, bus.o_test_ack, bus.o_timeout, bus.o_lanes_result};
    endfunction

    task automatic pulse_busy();
        bus.i_busy_negedge_detected = 1'b1;
        tick();
        bus.i_busy_negedge_detected = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] m);
        bus.i_decoded_sideband_message = m;
        tick();
        bus.i_decoded_sideband_message = 4'b0000;
    endtask

    // IDLE -> SEND_START_REQ -> (busy) -> WAIT_START_RESP; returns just after the entry edge.
    task automatic to_wait_start(input logic mode);
        bus.i_mainband_or_valtrain_test = mode;
        bus.i_en = 1'b1;
        tick();
        pulse_busy();
        tick();
    endtask

    // WAIT_START_RESP -> CAL_ALGO -> SEND_END_REQ -> WAIT_END_RESP; returns just after entry.
    task automatic to_wait_end(input logic [15:0] res);
        send_msg(4'b0010);
        bus.i_test_ack = 1'b1;
        bus.i_tx_lanes_result = res;
        tick();
        bus.i_test_ack = 1'b0;
        bus.i_tx_lanes_result = 16'h0;
        pulse_busy();
        tick();
    endtask

    task automatic stop_step();
        bus.i_en = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_en = 1'b0;
        bus.i_decoded_sideband_message = 4'b0000;
        bus.i_busy_negedge_detected = 1'b0;
        bus.i_valid_rx = 1'b0;
        bus.i_mainband_or_valtrain_test = 1'b0;
        bus.i_lfsr_or_perlane = 1'b0;
        bus.i_test_ack = 1'b0;
        bus.i_tx_lanes_result = 16'h0;

        tick(); tick();
        chk("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;
        tick();

        // Nominal mainband flow
        bus.i_en = 1'b1;
        tick();
        chk("nom_start_msg", 32'(bus.o_sideband_message), 32'h1);
        chk("nom_start_valid", 32'(bus.o_valid_tx), 32'h1);
        tick(); tick();
        pulse_busy();
        chk("nom_valid_clr", 32'(bus.o_valid_tx), 32'h0);
        chk("nom_msg_hold", 32'(bus.o_sideband_message), 32'h1);
        tick();
        chk("nom_pt_wait", 32'(bus.o_pt_en), 32'h0);
        send_msg(4'b0010);
        chk("nom_pt_en", 32'(bus.o_pt_en), 32'h1);
        chk("nom_sweep_en", 32'(bus.o_eye_width_sweep_en), 32'h1);
        repeat (19) tick();
        chk("nom_pt_hold", 32'(bus.o_pt_en), 32'h1);
        bus.i_test_ack = 1'b1;
        bus.i_tx_lanes_result = 16'hFFFF;
        tick();
        bus.i_test_ack = 1'b0;
        bus.i_tx_lanes_result = 16'h0;
        chk("nom_end_msg", 32'(bus.o_sideband_message), 32'h3);
        chk("nom_end_valid", 32'(bus.o_valid_tx), 32'h1);
        chk("nom_pt_off", 32'(bus.o_pt_en), 32'h0);
        chk("nom_sweep_off", 32'(bus.o_eye_width_sweep_en), 32'h0);
        chk("nom_lanes", 32'(bus.o_lanes_result), 32'hFFFF);
        pulse_busy();
        chk("nom_end_valid_clr", 32'(bus.o_valid_tx), 32'h0);
        tick();
        send_msg(4'b0100);
        chk("nom_test_ack", 32'(bus.o_test_ack), 32'h1);
        chk("nom_no_timeout", 32'(bus.o_timeout), 32'h0);
        chk("nom_lanes_hold", 32'(bus.o_lanes_result), 32'hFFFF);
        stop_step();
        chk("nom_idle_clear", all_outs(), 32'h0);

        // Valtrain: no sweep; then abort in CAL_ALGO
        to_wait_start(1'b1);
        send_msg(4'b0010);
        chk("vt_pt_en", 32'(bus.o_pt_en), 32'h1);
        chk("vt_sweep_off", 32'(bus.o_eye_width_sweep_en), 32'h0);
        stop_step();
        chk("abort_pt_off", 32'(bus.o_pt_en), 32'h0);
        chk("abort_all_clear", all_outs(), 32'h0);

        // Start-response timeout
        to_wait_start(1'b0);
        repeat (TO - 1) tick();
        chk("to_not_yet", 32'(bus.o_timeout), 32'h0);
        tick();
        chk("to_timeout", 32'(bus.o_timeout), 32'h1);
        chk("to_no_ack", 32'(bus.o_test_ack), 32'h0);
        chk("to_no_pt", 32'(bus.o_pt_en), 32'h0);
        stop_step();
        chk("to_clear", 32'(bus.o_timeout), 32'h0);

        // End response on the exact expiry cycle
        to_wait_start(1'b0);
        to_wait_end(16'h1234);
        repeat (TO - 1) tick();
        chk("bnd_not_yet", 32'(bus.o_timeout), 32'h0);
        send_msg(4'b0100);
        chk("bnd_test_ack", 32'(bus.o_test_ack), 32'h1);
        chk("bnd_no_timeout", 32'(bus.o_timeout), 32'h0);
        chk("bnd_lanes", 32'(bus.o_lanes_result), 32'h1234);
        stop_step();

        // Asynchronous reset in WAIT_END_RESP
        to_wait_start(1'b0);
        to_wait_end(16'hA5C3);
        tick();
        chk("rst_pre_lanes", 32'(bus.o_lanes_result), 32'hA5C3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_clear", all_outs(), 32'h0);
        bus.i_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Busy pulse colliding with the valid-set edge
        bus.i_en = 1'b1;
        bus.i_busy_negedge_detected = 1'b1;
        tick();
        bus.i_busy_negedge_detected = 1'b0;
        chk("col_valid_set", 32'(bus.o_valid_tx), 32'h1);
        chk("col_msg", 32'(bus.o_sideband_message), 32'h1);
        tick(); tick();
        chk("col_valid_hold", 32'(bus.o_valid_tx), 32'h1);
        pulse_busy();
        chk("col_valid_clr", 32'(bus.o_valid_tx), 32'h0);
        tick();
        send_msg(4'b0100);
        chk("col_unexpected_ignored", 32'(bus.o_pt_en), 32'h0);
        send_msg(4'b0010);
        chk("col_advance_pt", 32'(bus.o_pt_en), 32'h1);
        stop_step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
